// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and the reset NOP word.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_ERR  = 2'd2
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Wait-cycle watchdog for the fetch request: counts cycles without an ack and flags expiry.
module fetch_watchdog #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(MAX_WAIT + 2);
    localparam logic [CW-1:0] LAST = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // Fires on the MAX_WAIT-th consecutive un-acked cycle, so the error registers one edge later.
    assign expired = (MAX_WAIT > 0) && enable && !clear && (count == LAST);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over req/ack and presents them
// to decode over valid/ready, with redirect support and a stalled-memory watchdog.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              MAX_WAIT = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic            fetch_err
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pend_pc;
    logic            pend_valid;
    logic            redirect_bad;
    logic            wd_clear;
    logic            wd_enable;
    logic            wd_expired;

    assign redirect_bad = redirect && !word_aligned(redirect_pc[1:0]);
    assign wd_enable    = (state == S_REQ) && !imem_ack;
    assign wd_clear     = (state != S_REQ) || imem_ack;

    fetch_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            pend_pc    <= '0;
            pend_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_inst   <= INST_NOP;
            out_pc     <= '0;
            fetch_err  <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_bad) begin
                        fetch_err  <= 1'b1;
                        pend_valid <= 1'b0;
                        state      <= S_ERR;
                    end else if (wd_expired) begin
                        fetch_err  <= 1'b1;
                        state      <= S_ERR;
                    end else if (imem_ack) begin
                        // A redirect seen during this request makes the returned word stale.
                        if (redirect) begin
                            pc <= redirect_pc;
                        end else if (pend_valid) begin
                            pc <= pend_pc;
                        end else begin
                            out_inst  <= imem_rdata;
                            out_pc    <= pc;
                            out_valid <= 1'b1;
                            pc        <= pc + XLEN'(4);
                            state     <= S_HOLD;
                        end
                        pend_valid <= 1'b0;
                    end else if (redirect) begin
                        pend_valid <= 1'b1;
                        pend_pc    <= redirect_pc;
                    end
                end
                S_HOLD: begin
                    if (redirect_bad) begin
                        fetch_err <= 1'b1;
                        out_valid <= 1'b0;
                        state     <= S_ERR;
                    end else if (redirect) begin
                        out_valid <= 1'b0;
                        pc        <= redirect_pc;
                        state     <= S_REQ;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_REQ;
                    end
                end
                S_ERR: begin
                    out_valid <= 1'b0;
                end
                default: begin
                    out_valid <= 1'b0;
                    fetch_err <= 1'b1;
                    state     <= S_ERR;
                end
            endcase
        end
    end

    assign imem_req   = (state == S_REQ) && !rst;
    assign imem_addr  = pc;
    assign out_opcode = out_inst[6:0];
    assign out_funct3 = out_inst[14:12];
    assign out_funct7 = out_inst[31:25];

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: stimulus pushes expected fetches into a scoreboard,
// a negedge monitor pops and compares each instruction accepted by decode.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic        fetch_err;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    inst_fetch #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .fetch_err   (fetch_err)
    );

    // Memory contents: word at address a is a ^ 32'h4031_8233.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h4031_8233;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fetch at the expected address; leaves the bench in the first S_HOLD cycle.
    task automatic fetch_now(input string tag, input logic [31:0] addr_exp);
        chk1({tag, "_req"}, imem_req, 1'b1);
        chk({tag, "_addr"}, imem_addr, addr_exp);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        sb.push_back({addr_exp, mem_word(addr_exp)});
        step();
        imem_ack = 1'b0;
        chk1({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_pc"}, out_pc, addr_exp);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got pc %h expected no output", out_pc);
            end else begin
                e = sb.pop_front();
                chk("sb_inst", out_inst, e.inst);
                chk("sb_pc", out_pc, e.pc);
                chk("sb_opcode", 32'(out_opcode), 32'(e.inst[6:0]));
                chk("sb_funct3", 32'(out_funct3), 32'(e.inst[14:12]));
                chk("sb_funct7", 32'(out_funct7), 32'(e.inst[31:25]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b1;
        repeat (3) step();
        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", out_valid, 1'b0);
        chk("rst_inst", out_inst, 32'h0000_0013);
        chk("rst_pc", out_pc, 32'h0);
        chk1("rst_err", fetch_err, 1'b0);
        rst = 1'b0;
        #1;

        // Zero-wait streaming, 2-cycle cadence
        fetch_now("f0", 32'h0);
        chk("f0_opcode", 32'(out_opcode), 32'h33);
        chk("f0_funct3", 32'(out_funct3), 32'h0);
        chk("f0_funct7", 32'(out_funct7), 32'h20);
        step();
        fetch_now("f4", 32'h4);
        chk("f4_opcode", 32'(out_opcode), 32'h37);
        step();

        // Redirect while waiting on address 8
        chk("rd_addr0", imem_addr, 32'h8);
        step();
        chk("rd_addr1", imem_addr, 32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk1("rd_req2", imem_req, 1'b1);
        chk("rd_addr2", imem_addr, 32'h8);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        step();
        imem_ack = 1'b0;
        chk("rd_newaddr", imem_addr, 32'h100);
        chk1("rd_novalid", out_valid, 1'b0);
        fetch_now("f100", 32'h100);
        step();

        // Ack delayed by 3 cycles
        for (int k = 0; k < 3; k++) begin
            chk1("dly_req", imem_req, 1'b1);
            chk("dly_addr", imem_addr, 32'h104);
            step();
        end
        fetch_now("f104", 32'h104);
        chk("dly_inst", out_inst, mem_word(32'h104));
        chk1("dly_err", fetch_err, 1'b0);
        step();

        // Decode stalls for 5 cycles
        out_ready = 1'b0;
        fetch_now("f108", 32'h108);
        for (int k = 0; k < 5; k++) begin
            chk1("stl_valid", out_valid, 1'b1);
            chk("stl_inst", out_inst, mem_word(32'h108));
            chk("stl_pc", out_pc, 32'h108);
            chk1("stl_req", imem_req, 1'b0);
            step();
        end
        out_ready = 1'b1;
        step();

        // Redirect in the ack cycle, then PC wrap at the top of the address space
        chk("ackrd_addr", imem_addr, 32'h10C);
        imem_ack    = 1'b1;
        imem_rdata  = mem_word(imem_addr);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        imem_ack = 1'b0;
        redirect = 1'b0;
        chk("ackrd_newaddr", imem_addr, 32'hFFFF_FFFC);
        chk1("ackrd_novalid", out_valid, 1'b0);
        fetch_now("ftop", 32'hFFFF_FFFC);
        chk("ftop_funct3", 32'(out_funct3), 32'h7);
        step();
        chk("wrap_addr", imem_addr, 32'h0);
        chk1("wrap_err", fetch_err, 1'b0);

        // Watchdog: no ack for MAX_WAIT=4 cycles
        for (int k = 0; k < 4; k++) begin
            chk1("wd_err_low", fetch_err, 1'b0);
            chk1("wd_req", imem_req, 1'b1);
            step();
        end
        chk1("wd_err", fetch_err, 1'b1);
        chk1("wd_req_off", imem_req, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = mem_word(32'h0);
        step();
        imem_ack = 1'b0;
        chk1("wd_late_err", fetch_err, 1'b1);
        chk1("wd_late_valid", out_valid, 1'b0);
        chk1("wd_late_req", imem_req, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk1("wd_rst_err", fetch_err, 1'b0);
        chk("wd_rst_addr", imem_addr, 32'h0);
        chk1("wd_rst_req", imem_req, 1'b1);

        // Misaligned redirect beats a simultaneous ack
        imem_ack    = 1'b1;
        imem_rdata  = mem_word(imem_addr);
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        step();
        imem_ack = 1'b0;
        redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk1("mis_err", fetch_err, 1'b1);
            chk1("mis_req", imem_req, 1'b0);
            chk1("mis_valid", out_valid, 1'b0);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk1("mis_rst_err", fetch_err, 1'b0);
        chk("mis_rst_addr", imem_addr, 32'h0);
        chk1("mis_rst_req", imem_req, 1'b1);

        fetch_now("fend", 32'h0);
        step();
        step();
        chk("sb_drain", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
